// File: rtl/mult_operand_sequencer.sv
// Operand feeder for the Booth multiplier: buffers operand pairs, sequences
// the shared data bus and strobes, and hands back the product or a timeout.
module mult_operand_sequencer #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic [WIDTH-1:0]   mul_data,
    output logic               mul_ldM,
    output logic               mul_ldQ,
    output logic               mul_start,
    input  logic               mul_done,
    input  logic [2*WIDTH-1:0] mul_prod,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_prod,
    output logic               out_err,
    output logic               busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LDM   = 3'd1;
    localparam logic [2:0] S_LDQ   = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_HOLD  = 3'd5;

    logic [2:0]         state;
    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [CW-1:0]      cnt;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    // Extra pointer bit distinguishes full from empty when indices match
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = in_valid && !full;
    assign pop   = (state == S_IDLE) && !empty;

    assign in_ready  = !full;
    assign busy      = (state != S_IDLE) || !empty;
    assign mul_ldM   = (state == S_LDM);
    assign mul_ldQ   = (state == S_LDQ);
    assign mul_start = (state == S_START);

    always_comb begin
        mul_data = '0;
        unique case (state)
            S_LDM:   mul_data = op_a;
            S_LDQ:   mul_data = op_b;
            S_START: mul_data = op_b;
            default: mul_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {in_b, in_a};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_prod  <= '0;
            out_err   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case (state)
                S_IDLE: begin
                    if (pop) begin
                        {op_b, op_a} <= mem[rd_ptr[AW-1:0]];
                        state        <= S_LDM;
                    end
                end
                S_LDM:   state <= S_LDQ;
                S_LDQ:   state <= S_START;
                S_START: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    // done has priority over a coincident timeout
                    if (mul_done) begin
                        out_prod  <= mul_prod;
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_HOLD;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        out_prod  <= '0;
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// Directed bench for mult_operand_sequencer with a behavioural multiplier
// and a result scoreboard.
module tb_mult_operand_sequencer;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [15:0] mul_data;
    logic        mul_ldM;
    logic        mul_ldQ;
    logic        mul_start;
    logic        mul_done;
    logic [31:0] mul_prod;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_prod;
    logic        out_err;
    logic        busy;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [32:0] sb[$];

    logic [15:0] ma = '0;
    logic [15:0] mb = '0;
    int          mcnt = 0;
    int          model_n = 17;
    bit          model_en = 1'b1;
    logic        mdl_done = 1'b0;
    logic        spur_done = 1'b0;
    logic signed [31:0] mp;

    always #5 clk = ~clk;

    mult_operand_sequencer #(.WIDTH(16), .DEPTH(4), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
        .mul_data(mul_data), .mul_ldM(mul_ldM), .mul_ldQ(mul_ldQ),
        .mul_start(mul_start), .mul_done(mul_done), .mul_prod(mul_prod),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_prod(out_prod), .out_err(out_err), .busy(busy)
    );

    // Behavioural multiplier: latches operands, done pulse after start
    assign mp       = $signed(ma) * $signed(mb);
    assign mul_prod = mp;
    assign mul_done = mdl_done | spur_done;

    always @(posedge clk) begin
        if (mul_ldM) ma <= mul_data;
        if (mul_ldQ) mb <= mul_data;
        mdl_done <= model_en && (mcnt == 1);
        if (mul_start) mcnt <= model_n;
        else if (mcnt > 0) mcnt <= mcnt - 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", 64'(out_prod), 64'hdead);
            end else begin
                logic [32:0] e;
                e = sb.pop_front();
                chk("sb_result", {31'd0, out_err, out_prod}, {31'd0, e});
            end
        end
    end

    task automatic push(input logic [15:0] a, input logic [15:0] b,
                        input bit to);
        int k;
        logic signed [31:0] p;
        k = 0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (in_ready !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) chk("push_timeout", 64'(k), 64'd0);
        p = $signed(a) * $signed(b);
        sb.push_back(to ? {1'b1, 32'd0} : {1'b0, p});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while ((busy !== 1'b0 || out_valid !== 1'b0 || sb.size() != 0)
               && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("drain", 64'(k < 3000), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start();
        int k;
        k = 0;
        @(negedge clk);
        while (mul_start !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("see_start", 64'(k < 200), 64'd1);
    endtask

    initial begin
        int n;
        int strobes;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_oval", 64'(out_valid), 64'd0);
        chk("rst_ordy", 64'(in_ready), 64'd1);
        chk("rst_bus", {mul_ldM, mul_ldQ, mul_start, mul_data}, 64'd0);
        chk("rst_out", {out_err, out_prod}, 64'd0);

        // 1: strobe and bus sequencing
        @(posedge clk);
        #1 push(16'd3, 16'd5, 1'b0);
        @(negedge clk);
        chk("t1_idle", {mul_ldM, mul_ldQ, mul_start, mul_data}, 64'd0);
        @(negedge clk);
        chk("t1_ldm", {mul_ldM, mul_ldQ, mul_start, mul_data},
            {45'd0, 3'b100, 16'h0003});
        @(negedge clk);
        chk("t1_ldq", {mul_ldM, mul_ldQ, mul_start, mul_data},
            {45'd0, 3'b010, 16'h0005});
        @(negedge clk);
        chk("t1_start", {mul_ldM, mul_ldQ, mul_start},
            64'b001);
        wait_idle();

        // 2: negative product, held while out_ready low
        out_ready = 1'b0;
        push(16'hFFFE, 16'h0007, 1'b0);
        n = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t2_valid", 64'(n < 200), 64'd1);
        for (int i = 0; i < 10; i++) begin
            chk("t2_hold", {out_valid, out_err, out_prod},
                {30'd0, 2'b10, 32'hFFFFFFF2});
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_idle();

        // 3: five back-to-back pairs, fifo fills behind the first
        for (int i = 0; i < 5; i++) begin
            push(16'(100 * i - 150), 16'(3 * i + 1), 1'b0);
        end
        @(negedge clk);
        chk("t3_full", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 wait_idle();

        // 4: multiplier never completes
        model_en = 1'b0;
        push(16'd9, 16'd9, 1'b1);
        wait_start();
        n = 0;
        while (out_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        // TIMEOUT edges of WAIT after the edge leaving START
        chk("t4_latency", 64'(n), 64'(TO + 1));
        chk("t4_out", {out_err, out_prod}, {31'd0, 1'b1, 32'd0});
        model_en = 1'b1;
        @(posedge clk);
        #1 push(16'd12, 16'hFFFD, 1'b0);
        wait_idle();

        // 5: reset during WAIT with two pairs queued
        model_n = 30;
        push(16'd1, 16'd2, 1'b0);
        push(16'd3, 16'd4, 1'b0);
        push(16'd5, 16'd6, 1'b0);
        wait_start();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t5_state", {busy, out_valid, in_ready}, 64'b001);
        strobes = 0;
        for (int i = 0; i < 40; i++) begin
            if (mul_ldM || mul_ldQ || mul_start || out_valid) strobes++;
            @(negedge clk);
        end
        chk("t5_quiet", 64'(strobes), 64'd0);
        model_n = 17;

        // 6: spurious done in IDLE and LOAD_M
        @(posedge clk);
        #1 spur_done = 1'b1;
        @(posedge clk);
        #1 spur_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_idle", {busy, out_valid}, 64'd0);
        model_n = 10;
        @(posedge clk);
        #1 push(16'd7, 16'd11, 1'b0);
        @(posedge clk);
        #1 spur_done = 1'b1;
        @(negedge clk);
        chk("t6_ldm", 64'(mul_ldM), 64'd1);
        @(posedge clk);
        #1 spur_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_noval", 64'(out_valid), 64'd0);
        end
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
